// File: rtl/pcie_us_axi_dma_rd_desc_mux.sv
// Round-robin mux of client read descriptors onto one DMA read engine port, plus
// demux of completion status back to the originating client by tag prefix.
module pcie_us_axi_dma_rd_desc_mux #(
   parameter int PORTS           = 2,
   parameter int PCIE_ADDR_WIDTH = 64,
   parameter int AXI_ADDR_WIDTH  = 64,
   parameter int LEN_WIDTH       = 20,
   parameter int S_TAG_WIDTH     = 7,
   parameter int CL_PORTS        = $clog2(PORTS),
   parameter int M_TAG_WIDTH     = S_TAG_WIDTH + CL_PORTS
) (
   input  logic                               clk,
   input  logic                               rst_n,

   input  logic [PORTS*PCIE_ADDR_WIDTH-1:0]   s_axis_read_desc_pcie_addr,
   input  logic [PORTS*AXI_ADDR_WIDTH-1:0]    s_axis_read_desc_axi_addr,
   input  logic [PORTS*LEN_WIDTH-1:0]         s_axis_read_desc_len,
   input  logic [PORTS*S_TAG_WIDTH-1:0]       s_axis_read_desc_tag,
   input  logic [PORTS-1:0]                   s_axis_read_desc_valid,
   output logic [PORTS-1:0]                   s_axis_read_desc_ready,

   output logic [PCIE_ADDR_WIDTH-1:0]         m_axis_read_desc_pcie_addr,
   output logic [AXI_ADDR_WIDTH-1:0]          m_axis_read_desc_axi_addr,
   output logic [LEN_WIDTH-1:0]               m_axis_read_desc_len,
   output logic [M_TAG_WIDTH-1:0]             m_axis_read_desc_tag,
   output logic                               m_axis_read_desc_valid,
   input  logic                               m_axis_read_desc_ready,

   input  logic [M_TAG_WIDTH-1:0]             s_axis_read_desc_status_tag,
   input  logic                               s_axis_read_desc_status_valid,

   output logic [S_TAG_WIDTH-1:0]             m_axis_read_desc_status_tag,
   output logic [PORTS-1:0]                   m_axis_read_desc_status_valid,

   input  logic                               enable,
   output logic                               status_error_port
);

   logic [CL_PORTS-1:0]        r_ptr;
   logic                       r_m_valid;
   logic [PCIE_ADDR_WIDTH-1:0] r_m_pcie_addr;
   logic [AXI_ADDR_WIDTH-1:0]  r_m_axi_addr;
   logic [LEN_WIDTH-1:0]       r_m_len;
   logic [M_TAG_WIDTH-1:0]     r_m_tag;
   logic [PORTS-1:0]           r_stat_valid;
   logic [S_TAG_WIDTH-1:0]     r_stat_tag;
   logic                       r_stat_err;

   logic                       w_free;
   logic                       w_any;
   logic                       w_gnt;
   logic [CL_PORTS-1:0]        w_gnt_idx;
   logic [CL_PORTS-1:0]        w_ptr_next;
   logic [CL_PORTS-1:0]        w_stat_port;
   logic                       w_stat_ok;

   assign w_free = !r_m_valid || m_axis_read_desc_ready;

   // Scan from the highest offset down so the valid port closest to r_ptr wins.
   always_comb begin
      w_any     = 1'b0;
      w_gnt_idx = '0;
      for (int k = PORTS - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(r_ptr) + k) % PORTS;
         if (s_axis_read_desc_valid[idx]) begin
            w_any     = 1'b1;
            w_gnt_idx = CL_PORTS'(idx);
         end
      end
   end

   // rst_n gates the grant so no client sees ready while the block is held in reset.
   assign w_gnt      = w_any && enable && w_free && rst_n;
   assign w_ptr_next = (w_gnt_idx == CL_PORTS'(PORTS - 1)) ? '0 : w_gnt_idx + 1'b1;

   assign s_axis_read_desc_ready = w_gnt ? (PORTS'(1) << w_gnt_idx) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_ptr     <= '0;
      end else if (w_gnt) begin
         r_m_valid <= 1'b1;
         r_ptr     <= w_ptr_next;
      end else if (m_axis_read_desc_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_gnt) begin
         r_m_pcie_addr <= s_axis_read_desc_pcie_addr[w_gnt_idx*PCIE_ADDR_WIDTH +: PCIE_ADDR_WIDTH];
         r_m_axi_addr  <= s_axis_read_desc_axi_addr[w_gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
         r_m_len       <= s_axis_read_desc_len[w_gnt_idx*LEN_WIDTH +: LEN_WIDTH];
         r_m_tag       <= {w_gnt_idx, s_axis_read_desc_tag[w_gnt_idx*S_TAG_WIDTH +: S_TAG_WIDTH]};
      end
   end

   assign m_axis_read_desc_pcie_addr = r_m_pcie_addr;
   assign m_axis_read_desc_axi_addr  = r_m_axi_addr;
   assign m_axis_read_desc_len       = r_m_len;
   assign m_axis_read_desc_tag       = r_m_tag;
   assign m_axis_read_desc_valid     = r_m_valid;

   // Status path: tag prefix selects the client; non power-of-two PORTS leaves unused codes.
   assign w_stat_port = s_axis_read_desc_status_tag[M_TAG_WIDTH-1:S_TAG_WIDTH];
   assign w_stat_ok   = int'(w_stat_port) < PORTS;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_valid <= '0;
         r_stat_err   <= 1'b0;
      end else begin
         r_stat_valid <= (s_axis_read_desc_status_valid && w_stat_ok) ?
                         (PORTS'(1) << w_stat_port) : '0;
         r_stat_err   <= s_axis_read_desc_status_valid && !w_stat_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (s_axis_read_desc_status_valid)
         r_stat_tag <= s_axis_read_desc_status_tag[S_TAG_WIDTH-1:0];
   end

   assign m_axis_read_desc_status_tag   = r_stat_tag;
   assign m_axis_read_desc_status_valid = r_stat_valid;
   assign status_error_port             = r_stat_err;

endmodule

// File: tb/tb_pcie_us_axi_dma_rd_desc_mux.sv
// Directed bench: a 2-port mux for the descriptor/status paths and a 3-port mux
// for the out-of-range status index case.
module tb_pcie_us_axi_dma_rd_desc_mux;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   // 2-port instance
   logic [127:0] a_s_pcie = '0;
   logic [127:0] a_s_axi = '0;
   logic [39:0]  a_s_len = '0;
   logic [13:0]  a_s_tag = '0;
   logic [1:0]   a_s_valid = '0;
   logic [1:0]   a_s_ready;
   logic [63:0]  a_m_pcie;
   logic [63:0]  a_m_axi;
   logic [19:0]  a_m_len;
   logic [7:0]   a_m_tag;
   logic         a_m_valid;
   logic         a_m_ready = 1'b1;
   logic [7:0]   a_st_tag_in = '0;
   logic         a_st_valid_in = 1'b0;
   logic [6:0]   a_st_tag;
   logic [1:0]   a_st_valid;
   logic         a_enable = 1'b1;
   logic         a_err;

   // 3-port instance
   logic [191:0] b_s_pcie = '0;
   logic [191:0] b_s_axi = '0;
   logic [59:0]  b_s_len = '0;
   logic [20:0]  b_s_tag = '0;
   logic [2:0]   b_s_valid = '0;
   logic [2:0]   b_s_ready;
   logic [63:0]  b_m_pcie;
   logic [63:0]  b_m_axi;
   logic [19:0]  b_m_len;
   logic [8:0]   b_m_tag;
   logic         b_m_valid;
   logic [8:0]   b_st_tag_in = '0;
   logic         b_st_valid_in = 1'b0;
   logic [6:0]   b_st_tag;
   logic [2:0]   b_st_valid;
   logic         b_err;

   pcie_us_axi_dma_rd_desc_mux #(.PORTS(2)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .s_axis_read_desc_pcie_addr(a_s_pcie), .s_axis_read_desc_axi_addr(a_s_axi),
      .s_axis_read_desc_len(a_s_len), .s_axis_read_desc_tag(a_s_tag),
      .s_axis_read_desc_valid(a_s_valid), .s_axis_read_desc_ready(a_s_ready),
      .m_axis_read_desc_pcie_addr(a_m_pcie), .m_axis_read_desc_axi_addr(a_m_axi),
      .m_axis_read_desc_len(a_m_len), .m_axis_read_desc_tag(a_m_tag),
      .m_axis_read_desc_valid(a_m_valid), .m_axis_read_desc_ready(a_m_ready),
      .s_axis_read_desc_status_tag(a_st_tag_in), .s_axis_read_desc_status_valid(a_st_valid_in),
      .m_axis_read_desc_status_tag(a_st_tag), .m_axis_read_desc_status_valid(a_st_valid),
      .enable(a_enable), .status_error_port(a_err)
   );

   pcie_us_axi_dma_rd_desc_mux #(.PORTS(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .s_axis_read_desc_pcie_addr(b_s_pcie), .s_axis_read_desc_axi_addr(b_s_axi),
      .s_axis_read_desc_len(b_s_len), .s_axis_read_desc_tag(b_s_tag),
      .s_axis_read_desc_valid(b_s_valid), .s_axis_read_desc_ready(b_s_ready),
      .m_axis_read_desc_pcie_addr(b_m_pcie), .m_axis_read_desc_axi_addr(b_m_axi),
      .m_axis_read_desc_len(b_m_len), .m_axis_read_desc_tag(b_m_tag),
      .m_axis_read_desc_valid(b_m_valid), .m_axis_read_desc_ready(1'b1),
      .s_axis_read_desc_status_tag(b_st_tag_in), .s_axis_read_desc_status_valid(b_st_valid_in),
      .m_axis_read_desc_status_tag(b_st_tag), .m_axis_read_desc_status_valid(b_st_valid),
      .enable(1'b1), .status_error_port(b_err)
   );

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; #2; rst_n = 1'b1; #1;
   endtask

   task automatic set_desc(input int p, input logic [63:0] pa, input logic [63:0] aa,
                           input logic [19:0] l, input logic [6:0] t);
      a_s_pcie[p*64 +: 64] = pa;
      a_s_axi[p*64 +: 64]  = aa;
      a_s_len[p*20 +: 20]  = l;
      a_s_tag[p*7 +: 7]    = t;
   endtask

   task automatic test_reset();
      a_enable = 1'b1; a_s_valid = 2'b11; a_m_ready = 1'b1;
      repeat (2) step();
      tests++; if (a_m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b exp 0", a_m_valid); end
      tests++; if (a_s_ready !== 2'b00) begin fails++; $display("FAIL reset_s_ready got %b exp 00", a_s_ready); end
      tests++; if (a_st_valid !== 2'b00) begin fails++; $display("FAIL reset_st_valid got %b exp 00", a_st_valid); end
      tests++; if (a_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", a_err); end
      tests++; if (b_st_valid !== 3'b000 || b_err !== 1'b0) begin fails++; $display("FAIL reset_b_status got %b/%b exp 000/0", b_st_valid, b_err); end
      a_s_valid = 2'b00;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      set_desc(0, 64'h1000, 64'h2000, 20'h100, 7'h05);
      a_s_valid = 2'b01; a_m_ready = 1'b1;
      #1;
      tests++; if (a_s_ready !== 2'b01) begin fails++; $display("FAIL single_s_ready got %b exp 01", a_s_ready); end
      step();
      tests++; if (a_m_valid !== 1'b1) begin fails++; $display("FAIL single_m_valid got %b exp 1", a_m_valid); end
      tests++; if (a_m_tag !== 8'h05) begin fails++; $display("FAIL single_m_tag got %h exp 05", a_m_tag); end
      tests++; if (a_m_len !== 20'h100) begin fails++; $display("FAIL single_m_len got %h exp 100", a_m_len); end
      tests++; if (a_m_pcie !== 64'h1000 || a_m_axi !== 64'h2000) begin fails++; $display("FAIL single_addr got %h/%h exp 1000/2000", a_m_pcie, a_m_axi); end
      a_s_valid = 2'b00;
      #1;
      tests++; if (a_s_ready !== 2'b00) begin fails++; $display("FAIL single_s_ready_drop got %b exp 00", a_s_ready); end
      step();
      tests++; if (a_m_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", a_m_valid); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_rdy;
      logic [7:0] exp_tag;
      do_reset();
      set_desc(0, 64'h10, 64'h11, 20'h1, 7'h11);
      set_desc(1, 64'h20, 64'h21, 20'h2, 7'h22);
      a_s_valid = 2'b11; a_m_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_rdy = (i % 2) ? 2'b10 : 2'b01;
         exp_tag = (i % 2) ? 8'hA2 : 8'h11;
         #1;
         tests++; if (a_s_ready !== exp_rdy) begin fails++; $display("FAIL rr_s_ready[%0d] got %b exp %b", i, a_s_ready, exp_rdy); end
         step();
         tests++; if (a_m_valid !== 1'b1 || a_m_tag !== exp_tag) begin fails++; $display("FAIL rr_m_tag[%0d] got %b/%h exp 1/%h", i, a_m_valid, a_m_tag, exp_tag); end
      end
      a_s_valid = 2'b00;
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      a_m_ready = 1'b0;
      set_desc(1, 64'hAAAA, 64'hA0, 20'h33, 7'h33);
      a_s_valid = 2'b10;
      #1;
      tests++; if (a_s_ready !== 2'b10) begin fails++; $display("FAIL bp_first_grant got %b exp 10", a_s_ready); end
      step();
      tests++; if (a_m_valid !== 1'b1 || a_m_tag !== 8'hB3) begin fails++; $display("FAIL bp_load got %b/%h exp 1/b3", a_m_valid, a_m_tag); end
      set_desc(1, 64'hBBBB, 64'hB0, 20'h35, 7'h35);
      for (int i = 0; i < 5; i++) begin
         tests++; if (a_s_ready !== 2'b00) begin fails++; $display("FAIL bp_s_ready[%0d] got %b exp 00", i, a_s_ready); end
         tests++; if (a_m_valid !== 1'b1 || a_m_tag !== 8'hB3 || a_m_pcie !== 64'hAAAA) begin
            fails++; $display("FAIL bp_stable[%0d] got %b/%h/%h exp 1/b3/aaaa", i, a_m_valid, a_m_tag, a_m_pcie); end
         step();
      end
      a_m_ready = 1'b1;
      #1;
      tests++; if (a_s_ready !== 2'b10) begin fails++; $display("FAIL bp_release_grant got %b exp 10", a_s_ready); end
      step();
      tests++; if (a_m_valid !== 1'b1 || a_m_tag !== 8'hB5 || a_m_pcie !== 64'hBBBB) begin
         fails++; $display("FAIL bp_next got %b/%h/%h exp 1/b5/bbbb", a_m_valid, a_m_tag, a_m_pcie); end
      a_s_valid = 2'b00;
      step();
      tests++; if (a_m_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", a_m_valid); end
   endtask

   task automatic test_enable();
      do_reset();
      a_enable = 1'b0; a_m_ready = 1'b1;
      set_desc(0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 20'h0, 7'h0A);
      set_desc(1, 64'h5, 64'h6, 20'h7, 7'h0B);
      a_s_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         tests++; if (a_s_ready !== 2'b00 || a_m_valid !== 1'b0) begin fails++; $display("FAIL en_block[%0d] got %b/%b exp 00/0", i, a_s_ready, a_m_valid); end
         step();
      end
      a_enable = 1'b1;
      #1;
      tests++; if (a_s_ready !== 2'b01) begin fails++; $display("FAIL en_grant got %b exp 01", a_s_ready); end
      step();
      tests++; if (a_m_valid !== 1'b1 || a_m_tag !== 8'h0A) begin fails++; $display("FAIL en_out got %b/%h exp 1/0a", a_m_valid, a_m_tag); end
      tests++; if (a_m_len !== 20'h0 || a_m_axi !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL len0_pass got %h/%h exp 0/ffffffffffffffff", a_m_len, a_m_axi); end
      a_enable = 1'b0; a_m_ready = 1'b0;
      step();
      tests++; if (a_m_valid !== 1'b1 || a_s_ready !== 2'b00) begin fails++; $display("FAIL en_hold got %b/%b exp 1/00", a_m_valid, a_s_ready); end
      a_m_ready = 1'b1;
      step();
      tests++; if (a_m_valid !== 1'b0) begin fails++; $display("FAIL en_drain got %b exp 0", a_m_valid); end
      a_s_valid = 2'b00; a_enable = 1'b1;
   endtask

   task automatic test_status();
      a_st_tag_in = 8'h85; a_st_valid_in = 1'b1;
      step();
      a_st_tag_in = 8'h07;
      tests++; if (a_st_valid !== 2'b10 || a_st_tag !== 7'h05) begin fails++; $display("FAIL st_p1 got %b/%h exp 10/05", a_st_valid, a_st_tag); end
      step();
      a_st_valid_in = 1'b0;
      tests++; if (a_st_valid !== 2'b01 || a_st_tag !== 7'h07) begin fails++; $display("FAIL st_p0 got %b/%h exp 01/07", a_st_valid, a_st_tag); end
      step();
      tests++; if (a_st_valid !== 2'b00 || a_err !== 1'b0) begin fails++; $display("FAIL st_idle got %b/%b exp 00/0", a_st_valid, a_err); end
      b_st_tag_in = 9'h185; b_st_valid_in = 1'b1;
      step();
      b_st_tag_in = 9'h105;
      tests++; if (b_st_valid !== 3'b000 || b_err !== 1'b1) begin fails++; $display("FAIL st_bad_port got %b/%b exp 000/1", b_st_valid, b_err); end
      step();
      b_st_valid_in = 1'b0;
      tests++; if (b_st_valid !== 3'b100 || b_st_tag !== 7'h05 || b_err !== 1'b0) begin
         fails++; $display("FAIL st_p2 got %b/%h/%b exp 100/05/0", b_st_valid, b_st_tag, b_err); end
      step();
      tests++; if (b_st_valid !== 3'b000 || b_err !== 1'b0) begin fails++; $display("FAIL st_b_idle got %b/%b exp 000/0", b_st_valid, b_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      a_m_ready = 1'b0; a_enable = 1'b1;
      set_desc(1, 64'h44, 64'h44, 20'h44, 7'h44);
      a_s_valid = 2'b10;
      step();
      tests++; if (a_m_valid !== 1'b1 || a_m_tag !== 8'hC4) begin fails++; $display("FAIL rm_load got %b/%h exp 1/c4", a_m_valid, a_m_tag); end
      #2; rst_n = 1'b0; #1;
      tests++; if (a_m_valid !== 1'b0 || a_s_ready !== 2'b00) begin fails++; $display("FAIL rm_async got %b/%b exp 0/00", a_m_valid, a_s_ready); end
      set_desc(0, 64'h12, 64'h12, 20'h12, 7'h12);
      a_s_valid = 2'b11;
      #2; rst_n = 1'b1; a_m_ready = 1'b1; #1;
      tests++; if (a_s_ready !== 2'b01) begin fails++; $display("FAIL rm_first_grant got %b exp 01", a_s_ready); end
      step();
      tests++; if (a_m_valid !== 1'b1 || a_m_tag !== 8'h12) begin fails++; $display("FAIL rm_no_replay got %b/%h exp 1/12", a_m_valid, a_m_tag); end
      a_s_valid = 2'b00;
      step();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_enable();
      test_status();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pcie_us_axi_dma_rd_desc_mux.md
PCIE_US_AXI_DMA_RD_DESC_MUX -- requirements
Module: pcie_us_axi_dma_rd_desc_mux

Interface
REQ-001 The block SHALL have parameters: PORTS, default 2, number of client descriptor ports (2..8).
REQ-002 The block SHALL have parameters: PCIE_ADDR_WIDTH, default 64, PCIe address width; AXI_ADDR_WIDTH, default 64, AXI address width; LEN_WIDTH, default 20, length width.
REQ-003 The block SHALL have parameters: S_TAG_WIDTH, default 7, client tag width; CL_PORTS = $clog2(PORTS); M_TAG_WIDTH = S_TAG_WIDTH+CL_PORTS, tag width toward the DMA read engine.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-005 Ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-006 Ports: s_axis_read_desc_pcie_addr  in  PORTS*PCIE_ADDR_WIDTH; s_axis_read_desc_axi_addr  in  PORTS*AXI_ADDR_WIDTH; s_axis_read_desc_len  in  PORTS*LEN_WIDTH; s_axis_read_desc_tag  in  PORTS*S_TAG_WIDTH; s_axis_read_desc_valid  in  PORTS; s_axis_read_desc_ready  out  PORTS -- client descriptors, port i in slice i.
REQ-007 Ports: m_axis_read_desc_pcie_addr  out  PCIE_ADDR_WIDTH; m_axis_read_desc_axi_addr  out  AXI_ADDR_WIDTH; m_axis_read_desc_len  out  LEN_WIDTH; m_axis_read_desc_tag  out  M_TAG_WIDTH; m_axis_read_desc_valid  out  1; m_axis_read_desc_ready  in  1 -- to DMA read engine.
REQ-008 Ports: s_axis_read_desc_status_tag  in  M_TAG_WIDTH; s_axis_read_desc_status_valid  in  1 -- completion status from DMA read engine.
REQ-009 Ports: m_axis_read_desc_status_tag  out  S_TAG_WIDTH; m_axis_read_desc_status_valid  out  PORTS -- per-client completion status.
REQ-010 Ports: enable  in  1  permit new grants; status_error_port  out  1  pulse on status with out-of-range port index.

Function
REQ-011 Output stage SHALL be one register slot; "free" = !m_axis_read_desc_valid || m_axis_read_desc_ready.
REQ-012 When enable && free, the arbiter SHALL grant exactly one valid client per cycle, round-robin; s_axis_read_desc_ready[i] asserted combinationally only for granted port i.
REQ-013 Round-robin: priority pointer reset to port 0; after grant to port i, pointer becomes (i+1) mod PORTS; pointer unchanged on cycles without a grant.
REQ-014 Granted descriptor SHALL appear on m_axis_* the following cycle (latency 1); m_axis_read_desc_tag = {i[CL_PORTS-1:0], client tag}.
REQ-015 m_axis_* data SHALL be stable while m_axis_read_desc_valid && !m_axis_read_desc_ready.
REQ-016 Full throughput: with m_axis_read_desc_ready held high, one descriptor SHALL transfer per cycle.
REQ-017 enable low SHALL block new grants only; a descriptor already in the output slot SHALL remain valid until accepted.
REQ-018 Descriptor fields (including len = 0) SHALL pass unmodified; no length checking.
REQ-019 Status demux: on s_axis_read_desc_status_valid, port p = tag[M_TAG_WIDTH-1:S_TAG_WIDTH]; next cycle m_axis_read_desc_status_valid SHALL be one-hot bit p for one cycle, m_axis_read_desc_status_tag = tag[S_TAG_WIDTH-1:0].
REQ-020 If p >= PORTS, status SHALL be dropped (no valid bit) and status_error_port pulsed one cycle.
REQ-021 Status path SHALL accept one status per cycle with no backpressure, independent of descriptor path activity.

Reset
REQ-022 On rst_n low (asynchronous), m_axis_read_desc_valid, m_axis_read_desc_status_valid, status_error_port SHALL go 0 and the pointer SHALL return to 0; s_axis_read_desc_ready SHALL be 0 while rst_n is low.
REQ-023 Reset mid-transfer SHALL discard any held descriptor; no descriptor is replayed after release.
REQ-024 Data registers need not be reset.

Verification
REQ-025 PORTS=2, port 0 valid tag 0x05 len 0x100, m_ready=1 -> next cycle m_valid=1, m_tag=0x05, len 0x100; s_ready[0] high exactly one cycle.
REQ-026 Both ports valid continuously, m_ready=1 -> grants alternate 0,1,0,1; m_tag MSB toggles each cycle; 1 descriptor per cycle.
REQ-027 m_ready=0 for 5 cycles with port 1 descriptor held -> m_* stable, s_ready all 0 after first grant; m_ready=1 -> transfer, next grant the following cycle.
REQ-028 Status tag 0x85 valid -> next cycle m_status_valid=2'b10, m_status_tag=0x05; PORTS=3 with tag 0x185 (p=3) -> no valid, status_error_port=1 one cycle.
REQ-029 rst_n low while m_valid=1 -> m_valid 0 immediately (async); after release, first grant goes to port 0 when both ports valid.
REQ-030 enable=0 with both ports valid -> no s_ready, m_valid stays 0; enable=1 -> grant to port 0 next cycle.
